// File: rtl/mem_pkg.sv
`default_nettype none
// ============================================================================
// Module   : mem_pkg
// Brief    : Shared types and defaults for the MDR memory responder.
// Revision : 1.0 - initial release
// ============================================================================
package mem_pkg;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        WAIT   = 2'd1,
        ACCESS = 2'd2
    } mem_state_t;

    localparam int DEFAULT_DEPTH       = 512;
    localparam int DEFAULT_WAIT_STATES = 2;

    // Index width of a word-addressed array; never narrower than one bit.
    function automatic int addr_width(input int depth);
        return (depth > 1) ? $clog2(depth) : 1;
    endfunction

endpackage : mem_pkg
`default_nettype wire

// File: rtl/mem_array.sv
`default_nettype none
// ============================================================================
// Module   : mem_array
// Brief    : Single-port synchronous RAM, WIDTH x DEPTH, registered read port.
// Revision : 1.0 - initial release
// ============================================================================
module mem_array
    import mem_pkg::*;
#(
    parameter int WIDTH = 32,
    parameter int DEPTH = DEFAULT_DEPTH
)(
    input  logic                          clk,
    input  logic                          we,
    input  logic [addr_width(DEPTH)-1:0]  addr,
    input  logic [WIDTH-1:0]              wdata,
    output logic [WIDTH-1:0]              rdata
);

    logic [WIDTH-1:0] r_mem [DEPTH];

    // Contents are deliberately not reset; read returns the pre-write value.
    always_ff @(posedge clk) begin
        if (we) begin
            r_mem[addr] <= wdata;
        end
        rdata <= r_mem[addr];
    end

endmodule : mem_array
`default_nettype wire

// File: rtl/mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : mem_responder
// Brief    : Memory-side responder for the MDR: services MAR/MDR read/write
//            commands after WAIT_STATES cycles, pulses mem_ready on completion.
// Optional : define MEM_ERR_EN to flag out-of-range addresses on mem_error;
//            otherwise addresses wrap modulo DEPTH.
// Revision : 1.0 - initial release
// ============================================================================
module mem_responder
    import mem_pkg::*;
#(
    parameter int REG_SIZE    = 32,
    parameter int DEPTH       = DEFAULT_DEPTH,
    parameter int WAIT_STATES = DEFAULT_WAIT_STATES
)(
    input  logic                clk,
    input  logic                reset,
    input  logic                read,
    input  logic                write,
    input  logic [REG_SIZE-1:0] mar_addr,
    input  logic [REG_SIZE-1:0] mdr_output,
    output logic [REG_SIZE-1:0] m_data_in,
    output logic                mem_ready,
    output logic                mem_busy,
    output logic                mem_error
);

    localparam int         c_aw        = addr_width(DEPTH);
    localparam logic [3:0] c_wait_load = 4'((WAIT_STATES > 0) ? (WAIT_STATES - 1) : 0);

    mem_state_t          r_state;
    mem_state_t          w_state_nxt;
    logic [3:0]          r_cnt;
    logic [3:0]          w_cnt_nxt;
    logic                r_is_read;
    logic [c_aw-1:0]     r_addr;
    logic [REG_SIZE-1:0] r_wdata;

    logic                w_req;
    logic                w_accept;
    logic                w_access;
    logic                w_addr_hi;
    logic                w_err;
    logic [c_aw-1:0]     w_ram_addr;
    logic                w_ram_we;
    logic [REG_SIZE-1:0] w_ram_rdata;

    assign w_req     = read | write;
    assign w_accept  = (r_state == IDLE) && w_req;
    assign w_access  = (r_state == ACCESS);
    assign w_addr_hi = (mar_addr >> c_aw) != '0;
    assign mem_busy  = (r_state != IDLE);

`ifdef MEM_ERR_EN
    logic r_oor;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_oor <= 1'b0;
        end else if (w_accept) begin
            r_oor <= w_addr_hi;
        end
    end

    assign w_err = r_oor;
`else
    logic w_unused_addr_hi;

    assign w_unused_addr_hi = w_addr_hi;
    assign w_err            = 1'b0;
`endif

    // In IDLE the RAM reads the live MAR so the registered read data is
    // already valid by the time the command reaches ACCESS, even with no
    // wait states; afterwards it stays on the latched address.
    assign w_ram_addr = (r_state == IDLE) ? mar_addr[c_aw-1:0] : r_addr;
    assign w_ram_we   = w_access && !r_is_read && !w_err;

    mem_array #(
        .WIDTH (REG_SIZE),
        .DEPTH (DEPTH)
    ) u_mem_array (
        .clk   (clk),
        .we    (w_ram_we),
        .addr  (w_ram_addr),
        .wdata (r_wdata),
        .rdata (w_ram_rdata)
    );

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        case (r_state)
            IDLE: begin
                if (w_req) begin
                    if (WAIT_STATES == 0) begin
                        w_state_nxt = ACCESS;
                    end else begin
                        w_state_nxt = WAIT;
                        w_cnt_nxt   = c_wait_load;
                    end
                end
            end
            WAIT: begin
                if (r_cnt == 4'd0) begin
                    w_state_nxt = ACCESS;
                end else begin
                    w_cnt_nxt = r_cnt - 4'd1;
                end
            end
            ACCESS: begin
                w_state_nxt = IDLE;
            end
            default: begin
                w_state_nxt = IDLE;
                w_cnt_nxt   = 4'd0;
            end
        endcase
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
            r_cnt   <= 4'd0;
        end else begin
            r_state <= w_state_nxt;
            r_cnt   <= w_cnt_nxt;
        end
    end

    // Read wins when both requests are high.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            r_is_read <= 1'b0;
            r_addr    <= '0;
            r_wdata   <= '0;
        end else if (w_accept) begin
            r_is_read <= read;
            r_addr    <= mar_addr[c_aw-1:0];
            r_wdata   <= mdr_output;
        end
    end

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            m_data_in <= '0;
            mem_ready <= 1'b0;
            mem_error <= 1'b0;
        end else begin
            mem_ready <= w_access;
            mem_error <= w_access && w_err;
            if (w_access && r_is_read) begin
                m_data_in <= w_err ? '0 : w_ram_rdata;
            end
        end
    end

endmodule : mem_responder
`default_nettype wire

// File: tb/tb_mem_responder.sv
`default_nettype none
// ============================================================================
// Module   : tb_mem_responder
// Brief    : Self-checking bench for mem_responder against a cycle-count model.
// Revision : 1.0 - initial release
// ============================================================================
`timescale 1ns/1ps
module tb_mem_responder;

    localparam int W     = 32;
    localparam int DEPTH = 512;
    localparam int WS    = 2;
    localparam int AW    = $clog2(DEPTH);

    logic          clk        = 1'b0;
    logic          reset      = 1'b1;
    logic          read       = 1'b0;
    logic          write      = 1'b0;
    logic [W-1:0]  mar_addr   = '0;
    logic [W-1:0]  mdr_output = '0;
    logic [W-1:0]  m_data_in;
    logic          mem_ready;
    logic          mem_busy;
    logic          mem_error;

    int checks = 0;
    int passes = 0;

    mem_responder #(
        .REG_SIZE    (W),
        .DEPTH       (DEPTH),
        .WAIT_STATES (WS)
    ) dut (
        .clk        (clk),
        .reset      (reset),
        .read       (read),
        .write      (write),
        .mar_addr   (mar_addr),
        .mdr_output (mdr_output),
        .m_data_in  (m_data_in),
        .mem_ready  (mem_ready),
        .mem_busy   (mem_busy),
        .mem_error  (mem_error)
    );

    always #5 clk = ~clk;

    task automatic check(input string name, input logic [W-1:0] act, input logic [W-1:0] exp);
        checks++;
        if (act === exp) passes++;
        else $display("FAIL %s: got %h expected %h at %0t", name, act, exp, $time);
    endtask

    // Behavioural model: a command accepted at edge E completes at edge
    // E+WS+1; the responder is deaf to requests until that edge has passed.
    logic [W-1:0] ram_m [DEPTH];
    bit           pend = 1'b0;
    int           p_e  = 0;
    bit           p_rd = 1'b0;
    logic [W-1:0] p_addr = '0;
    logic [W-1:0] p_data = '0;
    logic [W-1:0] exp_data  = '0;
    bit           exp_ready = 1'b0;
    bit           exp_busy  = 1'b0;
    bit           exp_err   = 1'b0;
    int           cyc = 0;

    always @(posedge clk or posedge reset) begin : model
        bit done;
        int idx;
        if (reset) begin
            pend      = 1'b0;
            exp_data  = '0;
            exp_ready = 1'b0;
            exp_busy  = 1'b0;
            exp_err   = 1'b0;
        end else begin
            cyc++;
            done      = 1'b0;
            exp_ready = 1'b0;
            exp_err   = 1'b0;
            if (pend && cyc == p_e + WS + 1) begin
                idx = int'(p_addr % DEPTH);
`ifdef MEM_ERR_EN
                if ((p_addr >> AW) != 0) begin
                    exp_err = 1'b1;
                    if (p_rd) exp_data = '0;
                end else
`endif
                begin
                    if (p_rd) exp_data = ram_m[idx];
                    else      ram_m[idx] = p_data;
                end
                exp_ready = 1'b1;
                pend      = 1'b0;
                done      = 1'b1;
            end
            if (!pend && !done && (read || write)) begin
                pend   = 1'b1;
                p_e    = cyc;
                p_rd   = read;
                p_addr = mar_addr;
                p_data = mdr_output;
            end
            exp_busy = pend;
        end
    end

    bit chk_en = 1'b0;

    always @(negedge clk) begin
        if (chk_en) begin
            check("m_data_in", m_data_in, exp_data);
            check("mem_ready", mem_ready, exp_ready);
            check("mem_busy",  mem_busy,  exp_busy);
            check("mem_error", mem_error, exp_err);
        end
    end

    task automatic do_cmd(input bit rd, input bit wr, input logic [W-1:0] a,
                          input logic [W-1:0] d, input bit scramble,
                          output int lat, output logic [W-1:0] data, output bit err);
        @(negedge clk); #1;
        read = rd; write = wr; mar_addr = a; mdr_output = d;
        lat = 0; data = '0; err = 1'b0;
        if (scramble) begin
            @(posedge clk); #1;
            mar_addr = 32'h20; mdr_output = 32'h1234_5678;
        end
        for (int i = 0; i < 40; i++) begin
            @(negedge clk);
            lat++;
            if (mem_ready) begin
                data = m_data_in;
                err  = mem_error;
                break;
            end
        end
        if (!mem_ready) begin
            checks++;
            $display("FAIL timeout: no mem_ready within 40 cycles for addr %h", a);
        end
        #1;
        read = 1'b0; write = 1'b0;
    endtask

    initial begin : watchdog
        #2_000_000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin : stim
        int           lat;
        logic [W-1:0] d;
        bit           e;

        repeat (3) @(posedge clk);
        @(negedge clk);
        check("rst_data",  m_data_in, 32'h0);
        check("rst_ready", mem_ready, 1'b0);
        check("rst_busy",  mem_busy,  1'b0);
        check("rst_error", mem_error, 1'b0);
        #1 reset = 1'b0;
        chk_en = 1'b1;
        repeat (5) @(negedge clk);

        do_cmd(0, 1, 32'h20, 32'h2020_2020, 0, lat, d, e);
        do_cmd(0, 1, 32'h10, 32'hDEAD_BEEF, 0, lat, d, e);
        check("wr_latency", lat, WS + 2);
        do_cmd(1, 0, 32'h10, 32'h0, 0, lat, d, e);
        check("rd_latency", lat, WS + 2);
        check("rd_deadbeef", d, 32'hDEAD_BEEF);

        do_cmd(0, 1, 32'h10, 32'hA5A5_A5A5, 1, lat, d, e);
        do_cmd(1, 0, 32'h10, 32'h0, 0, lat, d, e);
        check("busy_wr_data", d, 32'hA5A5_A5A5);
        do_cmd(1, 0, 32'h20, 32'h0, 0, lat, d, e);
        check("busy_wr_other", d, 32'h2020_2020);

        do_cmd(1, 1, 32'h10, 32'hFFFF_FFFF, 0, lat, d, e);
        check("rw_is_read", d, 32'hA5A5_A5A5);
        do_cmd(1, 0, 32'h20, 32'h0, 0, lat, d, e);
        do_cmd(1, 0, 32'h10, 32'h0, 0, lat, d, e);
        check("rw_no_write", d, 32'hA5A5_A5A5);

        do_cmd(0, 1, 32'h30, 32'h11, 0, lat, d, e);
        @(negedge clk); #1;
        write = 1'b1; mar_addr = 32'h30; mdr_output = 32'h55;
        @(posedge clk); #1;
        write = 1'b0;
        @(negedge clk);
        check("busy_in_wait", mem_busy, 1'b1);
        #1 reset = 1'b1;
        #1;
        check("midrst_data",  m_data_in, 32'h0);
        check("midrst_busy",  mem_busy,  1'b0);
        check("midrst_ready", mem_ready, 1'b0);
        repeat (3) @(negedge clk);
        #1 reset = 1'b0;
        repeat (6) @(negedge clk);
        do_cmd(1, 0, 32'h30, 32'h0, 0, lat, d, e);
        check("rst_discards_wr", d, 32'h11);

        do_cmd(0, 1, 32'h0, 32'h0BAD_F00D, 0, lat, d, e);
        do_cmd(1, 0, 32'h200, 32'h0, 0, lat, d, e);
`ifdef MEM_ERR_EN
        check("oor_data", d, 32'h0);
        check("oor_err",  e, 1'b1);
`else
        check("oor_alias", d, 32'h0BAD_F00D);
        check("oor_err",   e, 1'b0);
`endif

        for (int a = 0; a < 64; a++) begin
            do_cmd(0, 1, a, $urandom, 0, lat, d, e);
        end

        for (int c = 0; c < 3000; c++) begin
            @(negedge clk); #1;
            read       = ($urandom_range(0, 3) == 0);
            write      = ($urandom_range(0, 2) == 0);
            mar_addr   = $urandom_range(0, 63);
            case ($urandom_range(0, 7))
                0:       mar_addr = mar_addr | 32'h0000_0200;
                1:       mar_addr = mar_addr | 32'h8000_0000;
                default: ;
            endcase
            mdr_output = $urandom;
            reset      = ($urandom_range(0, 199) == 0);
        end
        @(negedge clk); #1;
        read = 1'b0; write = 1'b0; reset = 1'b0;
        repeat (10) @(negedge clk);

        $display("%0d/%0d checks passed", passes, checks);
        $finish;
    end

endmodule : tb_mem_responder
`default_nettype wire
